// File: rtl/enigma_pkg.sv
// enigma_pkg
// Shared definitions for the cipher datapath front end and the
// row-permutation stage:
//   - state_e     : loader FSM states (FILL, FULL)
//   - BYTES_PER_BLOCK / ROWS : matrix geometry (16 bytes, 4 rows of 4)
//   - row_sel_t   : 2-bit row-select value, {s3, s4}
//   - pack_row    : packs four bytes into a row word, byte 0 at [7:0]
package enigma_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    localparam int BYTES_PER_BLOCK = 16;
    localparam int ROWS            = 4;

    typedef logic [1:0] row_sel_t;

    // Byte 0 of a row is the first byte received for that row and
    // lands in the least significant position.
    function automatic logic [31:0] pack_row(input logic [7:0] b0,
                                             input logic [7:0] b1,
                                             input logic [7:0] b2,
                                             input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/rerows_loader.sv
// rerows_loader
// Byte-serial loader for the row-permutation stage. Collects 16 bytes
// into a 4x4 matrix (rows w, x, y, z), presents it in parallel, and
// generates the row-select pair (s3, s4) that advances by SEL_STEP per
// delivered block.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_data/in_valid/in_ready   byte input handshake
//   abort                   drop the block being assembled or held
//   seed_load, sel_seed     load row select from the key path
//   out_w/x/y/z             matrix rows, byte 0 in [7:0]
//   s3, s4                  row select MSB / LSB
//   out_valid/out_ready     block output handshake
//   blk_cnt                 delivered-block counter, wraps at 16 bits
module rerows_loader
    import enigma_pkg::*;
#(
    parameter logic [1:0] SEL_STEP = 2'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        abort,
    input  logic        seed_load,
    input  logic [1:0]  sel_seed,
    output logic [31:0] out_w,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic [31:0] out_z,
    output logic        s3,
    output logic        s4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] blk_cnt
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    row_sel_t    sel_q, sel_d;
    logic [15:0] blk_cnt_q, blk_cnt_d;
    logic [7:0]  mat_q [BYTES_PER_BLOCK];
    logic [7:0]  mat_d [BYTES_PER_BLOCK];

    logic accept_s;
    logic deliver_s;

    // Handshake qualifiers; abort suppresses both acceptance and delivery.
    always_comb begin
        accept_s  = 1'b0;
        deliver_s = 1'b0;
        if (!abort) begin
            accept_s  = in_valid && (state_q == FILL);
            deliver_s = out_ready && (state_q == FULL);
        end else begin
            accept_s  = 1'b0;
            deliver_s = 1'b0;
        end
    end

    // Next-state, counters, select and matrix byte write decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        blk_cnt_d = blk_cnt_q;
        mat_d     = mat_q;

        case (state_q)
            FILL: begin
                if (accept_s) begin
                    // 4-bit counter wraps 15 -> 0 as the block completes
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = FULL;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            FULL: begin
                if (deliver_s) begin
                    state_d   = FILL;
                    sel_d     = sel_q + SEL_STEP;
                    blk_cnt_d = blk_cnt_q + 16'd1;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = 4'd0;
            end
        endcase

        // Byte write through index decode on the fill counter.
        for (int i = 0; i < BYTES_PER_BLOCK; i++) begin
            if (accept_s && (cnt_q == 4'(i))) begin
                mat_d[i] = in_data;
            end else begin
                mat_d[i] = mat_q[i];
            end
        end

        if (abort) begin
            state_d = FILL;
            cnt_d   = 4'd0;
        end else begin
            cnt_d = cnt_d;
        end

        // A seed load overrides the post-delivery step.
        if (seed_load) begin
            sel_d = sel_seed;
        end else begin
            sel_d = sel_d;
        end
    end

    // State, counter and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            cnt_q     <= 4'd0;
            sel_q     <= 2'd0;
            blk_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // Matrix byte registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BYTES_PER_BLOCK; i++) begin
                mat_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < BYTES_PER_BLOCK; i++) begin
                mat_q[i] <= mat_d[i];
            end
        end
    end

    // Outputs come straight from registers; no input-to-output paths.
    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign out_w     = pack_row(mat_q[0],  mat_q[1],  mat_q[2],  mat_q[3]);
    assign out_x     = pack_row(mat_q[4],  mat_q[5],  mat_q[6],  mat_q[7]);
    assign out_y     = pack_row(mat_q[8],  mat_q[9],  mat_q[10], mat_q[11]);
    assign out_z     = pack_row(mat_q[12], mat_q[13], mat_q[14], mat_q[15]);
    assign s3        = sel_q[1];
    assign s4        = sel_q[0];
    assign blk_cnt   = blk_cnt_q;

endmodule
